seq_round_ctrl: RTL and testbench
=================================

Name: seq_round_ctrl

Overview:
- Round controller for the memory-sequence game, directly upstream of the sequence decoder (SEQ3).
- Drives the decoder's 4-bit address input and reads back the 4-bit one-hot colour code it produces.
- Plays steps 0..round on the LEDs, then checks the player's button presses against the same steps.
- Reports hit, win and fail to the game top level.

Parameters:
- TICKS_ON, 4: tick strobes each step's LED stays lit during playback (>=1).
- TICKS_OFF, 2: tick strobes of dark gap after each step (>=1).
- TIMEOUT, 8: tick strobes allowed between presses in input phase before fail (>=1).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  one-cycle request to begin a round; sampled only in IDLE
- round  in  4  index of last step to play/check (0..15); latched on accepted start
- tick  in  1  one-cycle timing strobe (e.g. divided clock enable)
- seq_addr  out  4  registered address to decoder; equals current step index
- seq_val  in  4  one-hot code returned by decoder for seq_addr (combinational path)
- btn  in  4  one-cycle press pulses, already debounced/edge-detected
- leds  out  4  LED drive, combinational from state: seq_val in SHOW_ON, else 0000
- busy  out  1  high in every state except IDLE
- play_done  out  1  one-cycle pulse when playback ends
- hit  out  1  one-cycle pulse per correct press
- win  out  1  one-cycle pulse when the last step is matched
- fail  out  1  one-cycle pulse on wrong press or timeout

Behaviour:
- States: IDLE, SHOW_ON, SHOW_OFF, WAIT_IN.
- Registers: idx[3:0] (drives seq_addr), round_r[3:0], timer (width fits max parameter).
- Reset values:
  - state=IDLE, idx=0, round_r=0, timer=0.
  - seq_addr=0000, leds=0000, busy=0, all pulses 0.
- Reset wins over every other input in the same cycle, including mid-round.
- IDLE:
  - start=1 → round_r<=round, idx<=0, timer<=0, next SHOW_ON.
  - tick and btn are ignored.
- SHOW_ON:
  - leds=seq_val.
  - On tick: if timer==TICKS_ON-1 then timer<=0 and go to SHOW_OFF, else timer+1.
- SHOW_OFF:
  - leds=0000.
  - On tick with timer==TICKS_OFF-1: timer<=0, then:
    - idx==round_r → idx<=0, play_done=1, go to WAIT_IN;
    - otherwise idx<=idx+1, go to SHOW_ON.
  - On any other tick: timer+1.
- WAIT_IN (leds=0000):
  - btn==0000 and tick: if timer==TIMEOUT-1 then fail=1, go to IDLE; else timer+1.
  - btn!=0000 and btn==seq_val:
    - hit=1, timer<=0.
    - If idx==round_r: win=1, go to IDLE (hit and win in the same cycle). Otherwise idx<=idx+1.
  - btn!=0000 and btn!=seq_val (including multi-hot presses): fail=1, go to IDLE.
  - A press and a tick in the same cycle: the press takes priority and the tick is dropped.
- Returning to IDLE sets idx<=0, so seq_addr=0000 from the next cycle.
- Pulses are registered: asserted on the cycle after the triggering condition, for exactly one cycle. busy falls in the same cycle as win/fail.
- start or round changes while busy are ignored; round_r holds.
- round=15 plays all 16 steps. idx never exceeds round_r, so no wrap.
- The decoder is combinational, so seq_val is valid in the same cycle as seq_addr. No extra latency.

Test Plan:
- Reset: assert reset 3 cycles with tick, start and btn toggling → seq_addr=0000, leds=0000, busy=0, no pulses.
- Playback: tick every cycle, round=2, start pulse:
  - leds shows 0001×4, 0000×2, 0100×4, 0000×2, 0010×4, 0000×2;
  - then play_done pulse once, seq_addr=0000.
- Correct input: after the playback above, btn pulses 0001, 0100, 0010 → three hit pulses, win with the third, busy drops, state IDLE.
- Wrong press: round=1, after playback btn=0010 at idx 0 → fail pulse, no hit, busy=0. Repeat with btn=0101 → fail.
- Timeout: round=0, after playback 8 ticks with no press → fail on the 8th; a correct press on tick 7 gives hit+win instead.
- Disturbance:
  - reset during SHOW_ON → leds=0000 next cycle;
  - start pulse while busy → no restart;
  - round changed mid-play → played length unchanged;
  - round=15 → 16 steps played, seq_addr reaches 1111 without overflow.

Source files
------------

// File: rtl/seq_round_ctrl_if.sv
// Bundle between the game top level, the sequence decoder and the round controller.
// The controller takes the slave side; the top level (with the decoder) drives the master side.
interface seq_round_ctrl_if;
  logic       start;
  logic [3:0] round;
  logic       tick;
  logic [3:0] seq_addr;
  logic [3:0] seq_val;
  logic [3:0] btn;
  logic [3:0] leds;
  logic       busy;
  logic       play_done;
  logic       hit;
  logic       win;
  logic       fail;

  modport master (
    output start, round, tick, seq_val, btn,
    input  seq_addr, leds, busy, play_done, hit, win, fail
  );

  modport slave (
    input  start, round, tick, seq_val, btn,
    output seq_addr, leds, busy, play_done, hit, win, fail
  );
endinterface

// File: rtl/seq_round_ctrl.sv
// Round controller for the memory-sequence game: plays steps 0..round on the LEDs,
// then checks the player's presses against the same steps.
//
// state    | meaning
// IDLE     | waiting for start; tick and btn ignored
// SHOW_ON  | LED lit with decoder code for step idx
// SHOW_OFF | dark gap after a step
// WAIT_IN  | player input phase, timer counts ticks since last press
module seq_round_ctrl #(
  parameter int TICKS_ON  = 4,
  parameter int TICKS_OFF = 2,
  parameter int TIMEOUT   = 8
) (
  input logic             clock,
  input logic             reset,
  seq_round_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHOW_ON  = 2'd1;
  localparam logic [1:0] SHOW_OFF = 2'd2;
  localparam logic [1:0] WAIT_IN  = 2'd3;

  localparam int TMAX_A = (TICKS_ON > TICKS_OFF) ? TICKS_ON : TICKS_OFF;
  localparam int TMAX   = (TMAX_A > TIMEOUT) ? TMAX_A : TIMEOUT;
  localparam int TW     = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [TW-1:0] ON_LAST  = TW'(TICKS_ON - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(TICKS_OFF - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [3:0]    idx;
  logic [3:0]    round_r;
  logic [TW-1:0] timer;
  logic          play_done_r, hit_r, win_r, fail_r;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      round_r     <= '0;
      timer       <= '0;
      play_done_r <= 1'b0;
      hit_r       <= 1'b0;
      win_r       <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      play_done_r <= 1'b0;
      hit_r       <= 1'b0;
      win_r       <= 1'b0;
      fail_r      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            round_r <= bus.round;
            idx     <= '0;
            timer   <= '0;
            state   <= SHOW_ON;
          end
        end
        SHOW_ON: begin
          if (bus.tick) begin
            if (timer == ON_LAST) begin
              timer <= '0;
              state <= SHOW_OFF;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        SHOW_OFF: begin
          if (bus.tick) begin
            if (timer == OFF_LAST) begin
              timer <= '0;
              if (idx == round_r) begin
                idx         <= '0;
                play_done_r <= 1'b1;
                state       <= WAIT_IN;
              end else begin
                idx   <= idx + 1'b1;
                state <= SHOW_ON;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        WAIT_IN: begin
          // A press always beats a same-cycle tick.
          if (bus.btn != 4'b0000) begin
            timer <= '0;
            if (bus.btn == bus.seq_val) begin
              hit_r <= 1'b1;
              if (idx == round_r) begin
                win_r <= 1'b1;
                idx   <= '0;
                state <= IDLE;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              fail_r <= 1'b1;
              idx    <= '0;
              state  <= IDLE;
            end
          end else if (bus.tick) begin
            if (timer == TO_LAST) begin
              fail_r <= 1'b1;
              timer  <= '0;
              idx    <= '0;
              state  <= IDLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.seq_addr  = idx;
  assign bus.leds      = (state == SHOW_ON) ? bus.seq_val : 4'b0000;
  assign bus.busy      = (state != IDLE);
  assign bus.play_done = play_done_r;
  assign bus.hit       = hit_r;
  assign bus.win       = win_r;
  assign bus.fail      = fail_r;

endmodule

// File: tb/tb_seq_round_ctrl.sv
// Directed bench for seq_round_ctrl; models the sequence decoder as a fixed
// address-to-one-hot table and checks playback, input, timeout and disturbances.
module tb_seq_round_ctrl;
  localparam int TICKS_ON  = 4;
  localparam int TICKS_OFF = 2;
  localparam int TIMEOUT   = 8;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  seq_round_ctrl_if bus ();

  seq_round_ctrl #(.TICKS_ON(TICKS_ON), .TICKS_OFF(TICKS_OFF), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Decoder model: step 0 -> 0001, 1 -> 0100, 2 -> 0010, 3 -> 1000, repeating.
  function automatic logic [3:0] code(input logic [3:0] a);
    case (a[1:0])
      2'd0:    code = 4'b0001;
      2'd1:    code = 4'b0100;
      2'd2:    code = 4'b0010;
      default: code = 4'b1000;
    endcase
  endfunction

  assign bus.seq_val = code(bus.seq_addr);

  // Starts a round and walks playback, checking {leds, seq_addr, busy, play_done} each cycle.
  // With disturb set, a start pulse with a different round is injected mid-play.
  task automatic play(input logic [3:0] r, input bit disturb);
    int cyc;
    logic [9:0] obs, exp_v;
    cyc = 0;
    bus.round = r;
    bus.start = 1'b1;
    bus.tick  = 1'b1;
    @(negedge clock);
    for (int s = 0; s <= int'(r); s++) begin
      for (int t = 0; t < TICKS_ON + TICKS_OFF; t++) begin
        obs   = {bus.leds, bus.seq_addr, bus.busy, bus.play_done};
        exp_v = {(t < TICKS_ON) ? code(4'(s)) : 4'b0000, 4'(s), 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v)
          $display("FAIL play r=%0d step=%0d t=%0d {leds,addr,busy,done}: got %b want %b", r, s, t, obs, exp_v);
        else passed++;
        bus.start = 1'b0;
        if (disturb && cyc == 5) begin
          bus.start = 1'b1;
          bus.round = r + 4'd3;
        end
        cyc++;
        @(negedge clock);
      end
    end
    obs   = {bus.leds, bus.seq_addr, bus.busy, bus.play_done};
    exp_v = {4'b0000, 4'b0000, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v)
      $display("FAIL play_done r=%0d {leds,addr,busy,done}: got %b want %b", r, obs, exp_v);
    else passed++;
    bus.start = 1'b0;
    bus.tick  = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.tick  = i[0];
      bus.start = ~i[0];
      bus.btn   = i[0] ? 4'b0001 : 4'b0110;
      bus.round = 4'd5;
      @(negedge clock);
      obs = {bus.seq_addr, bus.leds, bus.busy, bus.play_done, bus.hit, bus.win, bus.fail, 3'b000};
      checks++;
      if (obs !== 16'h0000) $display("FAIL reset cycle %0d outputs: got %h want 0000", i, obs);
      else passed++;
    end
    bus.tick = 1'b0; bus.start = 1'b0; bus.btn = 4'b0000;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_release busy: got %b want 0", bus.busy);
    else passed++;
  endtask

  task automatic test_playback_and_input();
    logic [4:0] obs;
    play(4'd2, 1'b0);
    @(negedge clock);
    checks++;
    if (bus.play_done !== 1'b0) $display("FAIL play_done_width: got %b want 0", bus.play_done);
    else passed++;
    // presses: {hit, win, busy, addr[1:0]}
    bus.btn = 4'b0001; @(negedge clock);
    obs = {bus.hit, bus.win, bus.busy, bus.seq_addr[1:0]};
    checks++;
    if (obs !== 5'b10101 || bus.seq_addr[3:2] !== 2'b00) $display("FAIL press0 {hit,win,busy,addr}: got %b want 10101", obs);
    else passed++;
    bus.btn = 4'b0100; @(negedge clock);
    obs = {bus.hit, bus.win, bus.busy, bus.seq_addr[1:0]};
    checks++;
    if (obs !== 5'b10110) $display("FAIL press1 {hit,win,busy,addr}: got %b want 10110", obs);
    else passed++;
    bus.btn = 4'b0010; @(negedge clock);
    obs = {bus.hit, bus.win, bus.busy, bus.seq_addr[1:0]};
    checks++;
    if (obs !== 5'b11000) $display("FAIL press2_win {hit,win,busy,addr}: got %b want 11000", obs);
    else passed++;
    bus.btn = 4'b0000; @(negedge clock);
    checks++;
    if ({bus.hit, bus.win, bus.fail, bus.busy} !== 4'b0000)
      $display("FAIL after_win {hit,win,fail,busy}: got %b want 0000", {bus.hit, bus.win, bus.fail, bus.busy});
    else passed++;
  endtask

  task automatic test_wrong_press();
    logic [3:0] bad [2];
    bad[0] = 4'b0010;
    bad[1] = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      play(4'd1, 1'b0);
      bus.btn = bad[k]; @(negedge clock);
      bus.btn = 4'b0000;
      checks++;
      if ({bus.fail, bus.hit, bus.win, bus.busy} !== 4'b1000)
        $display("FAIL wrong_press btn=%b {fail,hit,win,busy}: got %b want 1000", bad[k], {bus.fail, bus.hit, bus.win, bus.busy});
      else passed++;
      @(negedge clock);
      checks++;
      if (bus.fail !== 1'b0) $display("FAIL wrong_press_width: got %b want 0", bus.fail);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    play(4'd0, 1'b0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      bus.tick = 1'b1; @(negedge clock);
      checks++;
      if ({bus.fail, bus.busy} !== ((k == TIMEOUT) ? 2'b10 : 2'b01))
        $display("FAIL timeout tick %0d {fail,busy}: got %b want %b", k, {bus.fail, bus.busy}, (k == TIMEOUT) ? 2'b10 : 2'b01);
      else passed++;
    end
    bus.tick = 1'b0;
    play(4'd0, 1'b0);
    for (int k = 1; k < TIMEOUT; k++) begin
      bus.tick = 1'b1;
      bus.btn  = (k == TIMEOUT - 1) ? 4'b0001 : 4'b0000;
      @(negedge clock);
    end
    bus.btn = 4'b0000;
    checks++;
    if ({bus.hit, bus.win, bus.fail, bus.busy} !== 4'b1100)
      $display("FAIL press_on_tick7 {hit,win,fail,busy}: got %b want 1100", {bus.hit, bus.win, bus.fail, bus.busy});
    else passed++;
    @(negedge clock);
    checks++;
    if ({bus.fail, bus.busy} !== 2'b00) $display("FAIL idle_after_win {fail,busy}: got %b want 00", {bus.fail, bus.busy});
    else passed++;
    bus.tick = 1'b0;
  endtask

  task automatic test_disturbance();
    bus.round = 4'd3; bus.start = 1'b1; bus.tick = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.leds !== 4'b0001) $display("FAIL pre_reset leds: got %b want 0001", bus.leds);
    else passed++;
    reset = 1'b1; @(negedge clock);
    reset = 1'b0; bus.tick = 1'b0;
    checks++;
    if ({bus.leds, bus.seq_addr, bus.busy} !== 9'b0)
      $display("FAIL reset_mid_round {leds,addr,busy}: got %b want 000000000", {bus.leds, bus.seq_addr, bus.busy});
    else passed++;
    @(negedge clock);
    play(4'd1, 1'b1);
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    play(4'd15, 1'b0);
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL final_idle busy: got %b want 0", bus.busy);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.round = 4'd0;
    bus.tick  = 1'b0;
    bus.btn   = 4'b0000;
    test_reset();
    test_playback_and_input();
    test_wrong_press();
    test_timeout();
    test_disturbance();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
